// File: rtl/alu16_seq.sv
// alu16_seq: serialized register-file/sequencer around an external 16-bit ALU (instr in_* handshake, alu_* drive/return, out_* result + flags)
module alu16_seq #(
  parameter int W = 16,
  parameter int NREG = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_cmd,
  input  logic [$clog2(NREG)-1:0] in_rd,
  input  logic [$clog2(NREG)-1:0] in_rs1,
  input  logic [$clog2(NREG)-1:0] in_rs2,
  input  logic [W-1:0]            in_imm,
  output logic [W-1:0]            alu_a,
  output logic [W-1:0]            alu_b,
  output logic [1:0]              alu_op,
  input  logic [W-1:0]            alu_y,
  input  logic                    alu_cout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [W-1:0]            out_data,
  output logic                    flag_z,
  output logic                    flag_n,
  output logic                    flag_c,
  output logic                    flag_v
);
  localparam int RW = $clog2(NREG);
  localparam logic [2:0] LOADI = 3'b100;
  localparam logic [2:0] READ = 3'b101;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [W-1:0] rf [NREG];
  logic [2:0] cmd_q;
  logic [RW-1:0] rd_q;
  logic [W-1:0] imm_q;
  logic [W-1:0] res_n;
  logic wr, cv, v_n, a15, b15, y15;
  assign in_ready = state == IDLE && !rst;
  assign out_valid = state == RESP;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state == IDLE ? (in_valid ? EXEC : IDLE) :
              state == EXEC ? RESP :
              (out_ready ? IDLE : RESP);
  end
  assign a15 = alu_a[W-1];
  assign b15 = alu_b[W-1];
  assign y15 = alu_y[W-1];
  always_comb begin
    res_n = !cmd_q[2] ? alu_y : cmd_q == LOADI ? imm_q : cmd_q == READ ? alu_a : '0;
    wr = !cmd_q[2] || cmd_q == LOADI;
    cv = cmd_q[2:1] == 2'b01;
    v_n = cmd_q[0] ? (a15 != b15 && y15 != a15) : (a15 == b15 && y15 != a15);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      cmd_q <= '0;
      rd_q <= '0;
      imm_q <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      out_data <= '0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        cmd_q <= in_cmd;
        rd_q <= in_rd;
        imm_q <= in_imm;
        alu_a <= rf[in_rs1];
        alu_b <= rf[in_rs2];
        if (!in_cmd[2]) alu_op <= in_cmd[1:0];
      end
      if (state == EXEC) begin
        out_data <= res_n;
        if (wr && rd_q != '0) rf[rd_q] <= res_n;
        if (wr) begin
          flag_z <= res_n == '0;
          flag_n <= res_n[W-1];
        end
        if (cv) begin
          flag_c <= alu_cout;
          flag_v <= v_n;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: directed + random checks of alu16_seq against a behavioural model, with an ideal ALU attached
module tb_alu16_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [2:0] in_cmd = '0, in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [15:0] in_imm = '0;
  logic [15:0] alu_a, alu_b, alu_y;
  logic [1:0] alu_op;
  logic alu_cout;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_data;
  logic flag_z, flag_n, flag_c, flag_v;
  logic [16:0] sum17;
  int passed = 0;
  int total = 0;
  logic [15:0] m_rf [8];
  logic mz, mn, mc, mv;
  always #5 clk = ~clk;
  alu16_seq #(.W(16), .NREG(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
  );
  always_comb begin
    sum17 = alu_op == 2'b11 ? {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1 : {1'b0, alu_a} + {1'b0, alu_b};
    alu_y = alu_op == 2'b00 ? alu_a & alu_b : alu_op == 2'b01 ? alu_a | alu_b : sum17[15:0];
    alu_cout = alu_op[1] ? sum17[16] : 1'b0;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    {mz, mn, mc, mv} = '0;
  endtask
  task automatic model(input logic [2:0] cmd, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input logic [15:0] imm, output logic [15:0] res);
    int a, b, s, sa, sb, ss;
    a = int'(m_rf[rs1]);
    b = int'(m_rf[rs2]);
    sa = a >= 32768 ? a - 65536 : a;
    sb = b >= 32768 ? b - 65536 : b;
    res = '0;
    case (cmd)
      3'd0: res = 16'(a & b);
      3'd1: res = 16'(a | b);
      3'd2: begin
        s = a + b;
        res = 16'(s);
        mc = s > 65535;
        ss = sa + sb;
        mv = ss > 32767 || ss < -32768;
      end
      3'd3: begin
        s = a - b;
        res = 16'(s);
        mc = a >= b;
        ss = sa - sb;
        mv = ss > 32767 || ss < -32768;
      end
      3'd4: res = imm;
      3'd5: res = m_rf[rs1];
      default: res = '0;
    endcase
    if (cmd <= 3'd4) begin
      mz = res == 16'd0;
      mn = res[15];
      if (rd != 3'd0) m_rf[rd] = res;
    end
  endtask
  task automatic exec(input logic [2:0] cmd, input logic [2:0] rd, input logic [2:0] rs1,
                      input logic [2:0] rs2, input logic [15:0] imm, input int stall);
    logic [15:0] exp;
    model(cmd, rd, rs1, rs2, imm, exp);
    @(negedge clk);
    in_cmd = cmd; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    chk("accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("lat_exec_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_resp_valid", 32'(out_valid), 32'd1);
    chk("data", 32'(out_data), 32'(exp));
    chk("flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'({mz, mn, mc, mv}));
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      in_cmd = 3'd4; in_rd = 3'd7; in_imm = 16'hBEEF; in_valid = 1'b1;
      chk("stall_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'(exp));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("pop_ready", 32'(in_ready), 32'd1);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'({out_data, alu_op}), 32'd0);
    chk("rst_ops", 32'({alu_a, alu_b}), 32'd0);
    chk("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_ready", 32'(in_ready), 32'd1);
    exec(3'd4, 3'd1, 3'd0, 3'd0, 16'h1234, 0);
    exec(3'd4, 3'd2, 3'd0, 3'd0, 16'h00FF, 0);
    exec(3'd0, 3'd3, 3'd1, 3'd2, 16'h0, 0);
    chk("and_const", 32'(out_data), 32'h0034);
    exec(3'd5, 3'd0, 3'd3, 3'd0, 16'h0, 0);
    chk("read_const", 32'(out_data), 32'h0034);
    exec(3'd4, 3'd1, 3'd0, 3'd0, 16'hFFFF, 0);
    exec(3'd4, 3'd2, 3'd0, 3'd0, 16'h0001, 0);
    exec(3'd2, 3'd3, 3'd1, 3'd2, 16'h0, 0);
    chk("add_wrap_const", 32'({out_data, flag_z, flag_c, flag_v}), 32'({16'h0000, 3'b110}));
    exec(3'd1, 3'd4, 3'd1, 3'd2, 16'h0, 0);
    chk("or_const", 32'({out_data, flag_n, flag_c, flag_v}), 32'({16'hFFFF, 3'b110}));
    exec(3'd4, 3'd1, 3'd0, 3'd0, 16'h7FFF, 0);
    exec(3'd2, 3'd3, 3'd1, 3'd2, 16'h0, 0);
    chk("add_ovf_const", 32'({out_data, flag_n, flag_c, flag_v}), 32'({16'h8000, 3'b101}));
    exec(3'd4, 3'd1, 3'd0, 3'd0, 16'h8000, 0);
    exec(3'd3, 3'd3, 3'd1, 3'd2, 16'h0, 0);
    chk("sub_ovf_const", 32'({out_data, flag_c, flag_v}), 32'({16'h7FFF, 2'b11}));
    exec(3'd4, 3'd0, 3'd0, 3'd0, 16'h5555, 0);
    exec(3'd5, 3'd0, 3'd0, 3'd0, 16'h0, 0);
    chk("r0_const", 32'(out_data), 32'h0000);
    exec(3'd3, 3'd5, 3'd2, 3'd2, 16'h0, 0);
    chk("sub_self_const", 32'({out_data, flag_z, flag_c, flag_v}), 32'({16'h0000, 3'b110}));
    exec(3'd2, 3'd6, 3'd1, 3'd2, 16'h0, 5);
    exec(3'd5, 3'd0, 3'd7, 3'd0, 16'h0, 0);
    chk("stall_ignored", 32'(out_data), 32'h0000);
    exec(3'd6, 3'd3, 3'd1, 3'd2, 16'h0, 0);
    @(negedge clk);
    in_cmd = 3'd2; in_rd = 3'd6; in_rs1 = 3'd1; in_rs2 = 3'd2; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    exec(3'd5, 3'd0, 3'd6, 3'd0, 16'h0, 0);
    chk("abort_r6", 32'(out_data), 32'h0000);
    for (int t = 0; t < 60; t++)
      exec(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 16'($urandom), int'($urandom_range(0, 2)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
